// File: rtl/bus_cmd_pkg.sv
// Shared types and constants for the host-command register-bus initiator.
// Covers FSM states, response status codes and the command header layout.
package bus_cmd_pkg;

   typedef enum logic [2:0] {
      IDLE, ADDR_LO, ADDR_HI, WDATA, BUS, RDATA, STATUS, DRAIN
   } state_t;

   localparam logic [7:0] ST_OK      = 8'h00;
   localparam logic [7:0] ST_TIMEOUT = 8'hFE;
   localparam logic [7:0] ST_BADHDR  = 8'hFF;

   localparam int HDR_WE     = 7;
   localparam int HDR_RSV_HI = 6;
   localparam int HDR_RSV_LO = 4;
   localparam int HDR_CNT_HI = 3;
   localparam int HDR_CNT_LO = 0;

   function automatic logic hdr_ok(input logic [7:0] hdr);
      return hdr[HDR_RSV_HI:HDR_RSV_LO] == 3'b000;
   endfunction

endpackage

// File: rtl/bus_cmd_word_shift.sv
// 32-bit word register with a byte index: rx bytes load LSB first,
// bus read data loads in parallel, tx bytes unload LSB first.
module bus_cmd_word_shift (
   input  logic        clk_48,
   input  logic        rst_n,
   input  logic        clr,
   input  logic        byte_load,
   input  logic [7:0]  byte_in,
   input  logic        word_load,
   input  logic [31:0] word_in,
   input  logic        unload,
   output logic [31:0] word,
   output logic [7:0]  byte_out,
   output logic [1:0]  idx
);

   logic [31:0] word_q;
   logic [1:0]  idx_q;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk_48 or negedge rst_n) begin
      if (!rst_n) begin
         word_q <= '0;
         idx_q  <= '0;
      end else if (word_load) begin
         word_q <= word_in;
         idx_q  <= '0;
      end else if (clr) begin
         idx_q <= '0;
      end else if (byte_load) begin
         word_q[{idx_q, 3'b000} +: 8] <= byte_in;
         idx_q <= idx_q + 2'd1;
      end else if (unload) begin
         idx_q <= idx_q + 2'd1;
      end
   end

   assign word     = word_q;
   assign idx      = idx_q;
   assign byte_out = word_q[{idx_q, 3'b000} +: 8];

endmodule

// File: rtl/bus_cmd_master.sv
// Parses host command packets from a byte stream and turns them into single
// or burst accesses on the avalid/aready register bus, returning data/status.
module bus_cmd_master
   import bus_cmd_pkg::*;
#(
   parameter int TIMEOUT = 1024
) (
   input  logic        clk_48,
   input  logic        rst_n,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        avalid,
   input  logic        aready,
   output logic        awe,
   output logic [13:0] aaddr,
   output logic [31:0] adata,
   input  logic        bvalid,
   input  logic [31:0] bdata,
   output logic        busy
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

   state_t         state, state_nx;
   logic           we_q;
   logic [3:0]     rem;
   logic [5:0]     drain_left;
   logic [7:0]     status_q;
   logic [TW-1:0]  tmo_cnt;
   logic           rx_fire, tx_fire, bus_done, tmo_hit, more;
   logic [1:0]     idx;
   logic [7:0]     sh_byte;
   logic [31:0]    sh_word;

   assign rx_ready = state inside {IDLE, ADDR_LO, ADDR_HI, WDATA, DRAIN};
   assign tx_valid = (state == RDATA) || (state == STATUS);
   assign busy     = state != IDLE;
   assign rx_fire  = rx_valid && rx_ready;
   assign tx_fire  = tx_valid && tx_ready;
   assign bus_done = (state == BUS) && avalid && aready;
   // Abort on the cycle that would make TIMEOUT stalled cycles.
   assign tmo_hit  = (state == BUS) && avalid && !aready && (tmo_cnt == TMO_LAST);
   assign more     = rem != 4'd0;
   assign awe      = avalid && we_q;
   assign adata    = sh_word;
   assign tx_data  = (state == STATUS) ? status_q :
                     (state == RDATA)  ? sh_byte  : 8'h00;

   bus_cmd_word_shift u_shift (
      .clk_48    (clk_48),
      .rst_n     (rst_n),
      .clr       (state == IDLE),
      .byte_load (rx_fire && (state == WDATA)),
      .byte_in   (rx_data),
      .word_load (bus_done && !we_q && bvalid),
      .word_in   (bdata),
      .unload    (tx_fire && (state == RDATA)),
      .word      (sh_word),
      .byte_out  (sh_byte),
      .idx       (idx)
   );

   always_ff @(posedge clk_48 or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // NOTE: state_nx gets a default before the case so no path infers a latch.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (rx_fire) state_nx = hdr_ok(rx_data) ? ADDR_LO : STATUS;
         ADDR_LO: if (rx_fire) state_nx = ADDR_HI;
         ADDR_HI: if (rx_fire) state_nx = we_q ? WDATA : BUS;
         WDATA:   if (rx_fire && idx == 2'd3) state_nx = BUS;
         BUS: begin
            if (bus_done)     state_nx = !we_q ? RDATA : (more ? WDATA : STATUS);
            else if (tmo_hit) state_nx = (we_q && more) ? DRAIN : STATUS;
         end
         RDATA:   if (tx_fire && idx == 2'd3) state_nx = more ? BUS : IDLE;
         STATUS:  if (tx_fire) state_nx = IDLE;
         DRAIN:   if (rx_fire && drain_left == 6'd1) state_nx = STATUS;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk_48 or negedge rst_n) begin
      if (!rst_n) begin
         we_q       <= 1'b0;
         rem        <= '0;
         drain_left <= '0;
         status_q   <= ST_OK;
         tmo_cnt    <= '0;
         avalid     <= 1'b0;
         aaddr      <= '0;
      end else begin
         if (state != BUS)
            tmo_cnt <= '0;
         else if (avalid && !aready)
            tmo_cnt <= tmo_cnt + TW'(1);

         case (state)
            IDLE: if (rx_fire) begin
               we_q     <= rx_data[HDR_WE];
               rem      <= rx_data[HDR_CNT_HI:HDR_CNT_LO];
               status_q <= hdr_ok(rx_data) ? ST_OK : ST_BADHDR;
            end
            ADDR_LO: if (rx_fire) aaddr[5:0]  <= rx_data[7:2];
            ADDR_HI: if (rx_fire) aaddr[13:6] <= rx_data;
            BUS: begin
               if (bus_done) begin
                  avalid <= 1'b0;
                  aaddr  <= aaddr + 14'd1;
                  if (we_q && more) rem <= rem - 4'd1;
               end else if (tmo_hit) begin
                  avalid     <= 1'b0;
                  status_q   <= ST_TIMEOUT;
                  drain_left <= {rem, 2'b00};
               end else begin
                  avalid <= 1'b1;
               end
            end
            RDATA: if (tx_fire && idx == 2'd3 && more) rem <= rem - 4'd1;
            DRAIN: if (rx_fire) drain_left <= drain_left - 6'd1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_bus_cmd_master.sv
// Scoreboard bench for bus_cmd_master: a bus responder and tx sink on the
// falling edge compare every request and response byte against queued values.
module tb_bus_cmd_master;

   logic        clk_48 = 1'b0;
   logic        rst_n = 1'b1;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic        rx_ready;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b1;
   logic        avalid;
   logic        aready = 1'b0;
   logic        awe;
   logic [13:0] aaddr;
   logic [31:0] adata;
   logic        bvalid = 1'b0;
   logic [31:0] bdata = '0;
   logic        busy;

   always #5 clk_48 = ~clk_48;

   bus_cmd_master #(.TIMEOUT(16)) dut (
      .clk_48   (clk_48),
      .rst_n    (rst_n),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_ready (rx_ready),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .avalid   (avalid),
      .aready   (aready),
      .awe      (awe),
      .aaddr    (aaddr),
      .adata    (adata),
      .bvalid   (bvalid),
      .bdata    (bdata),
      .busy     (busy)
   );

   typedef struct {
      logic        we;
      logic [13:0] addr;
      logic [31:0] data;
   } req_t;

   req_t        exp_req[$];
   logic [7:0]  exp_tx[$];
   logic [31:0] rd_q[$];
   logic [7:0]  pkt[$];
   req_t        r;
   int          n_cmp = 0;
   int          n_err = 0;
   int          req_seen = 0;
   int          tx_seen = 0;
   int          av_run = 0;
   int          last_run = 0;
   int          stall_after = -1;
   int          stall_left = 0;
   bit          resp_never = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Responder and tx sink: decide the handshakes for the coming edge, then score them.
   always @(negedge clk_48) begin
      if (!rst_n) begin
         aready = 1'b0;
         bvalid = 1'b0;
         bdata  = '0;
         tx_ready = 1'b1;
         av_run = 0;
      end else begin
         if (avalid) av_run++;
         else begin
            if (av_run > 0) last_run = av_run;
            av_run = 0;
         end
         aready = avalid && !resp_never;
         bvalid = aready && !awe;
         bdata  = '0;
         if (aready) begin
            req_seen++;
            if (exp_req.size() > 0) begin
               r = exp_req.pop_front();
               check("req_awe", awe, r.we);
               check("req_aaddr", aaddr, r.addr);
               if (r.we) check("req_adata", adata, r.data);
            end
            if (bvalid && rd_q.size() > 0) bdata = rd_q.pop_front();
         end

         if (stall_after >= 0 && tx_seen == stall_after) begin
            stall_left  = 10;
            stall_after = -1;
         end
         if (stall_left > 0) begin
            tx_ready = 1'b0;
            stall_left--;
            check("stall_tx_valid", tx_valid, 1'b1);
            if (exp_tx.size() > 0) check("stall_tx_data", tx_data, exp_tx[0]);
            check("stall_avalid", avalid, 1'b0);
         end else begin
            tx_ready = 1'b1;
         end
         if (tx_valid && tx_ready) begin
            tx_seen++;
            if (exp_tx.size() > 0) check("tx_data", tx_data, exp_tx.pop_front());
         end
      end
   end

   task automatic send(input logic [7:0] b);
      bit accepted = 1'b0;
      rx_data  = b;
      rx_valid = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk_48);
         if (rx_ready) begin
            @(posedge clk_48);
            accepted = 1'b1;
            break;
         end
      end
      #1 rx_valid = 1'b0;
      check("rx_accept", accepted, 1'b1);
   endtask

   task automatic send_pkt();
      foreach (pkt[i]) send(pkt[i]);
   endtask

   task automatic wait_done(input string name, input int nreq, input int ntx);
      for (int i = 0; i < 400; i++) begin
         @(negedge clk_48);
         if (exp_tx.size() == 0 && exp_req.size() == 0) break;
      end
      @(negedge clk_48);
      check({name, "_busy_end"}, busy, 1'b0);
      repeat (5) @(negedge clk_48);
      check({name, "_req_count"}, req_seen, nreq);
      check({name, "_tx_count"}, tx_seen, ntx);
      req_seen = 0;
      tx_seen  = 0;
      @(posedge clk_48);
      #1;
   endtask

   initial begin
      #1 rst_n = 1'b0;
      #1;
      check("rst_avalid", avalid, 1'b0);
      check("rst_awe", awe, 1'b0);
      check("rst_aaddr", aaddr, 14'h0);
      check("rst_adata", adata, 32'h0);
      check("rst_tx_valid", tx_valid, 1'b0);
      check("rst_tx_data", tx_data, 8'h00);
      check("rst_busy", busy, 1'b0);
      check("rst_rx_ready", rx_ready, 1'b1);
      repeat (3) @(posedge clk_48);
      #1 rst_n = 1'b1;

      // Single write
      exp_req.push_back('{1'b1, 14'h0001, 32'h12345678});
      exp_tx.push_back(8'h00);
      pkt = '{8'h80, 8'h04, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
      send_pkt();
      wait_done("wr1", 1, 1);

      // Burst read of two words
      rd_q.push_back(32'hAABBCCDD);
      rd_q.push_back(32'h11223344);
      exp_req.push_back('{1'b0, 14'h0040, 32'h0});
      exp_req.push_back('{1'b0, 14'h0041, 32'h0});
      exp_tx = '{8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'h44, 8'h33, 8'h22, 8'h11};
      pkt = '{8'h01, 8'h00, 8'h01};
      send_pkt();
      wait_done("rd2", 2, 8);

      // Bad header, then a read at address 0
      exp_tx.push_back(8'hFF);
      pkt = '{8'h70};
      send_pkt();
      wait_done("badhdr", 0, 1);
      rd_q.push_back(32'hCAFEF00D);
      exp_req.push_back('{1'b0, 14'h0000, 32'h0});
      exp_tx = '{8'h0D, 8'hF0, 8'hFE, 8'hCA};
      pkt = '{8'h00, 8'h00, 8'h00};
      send_pkt();
      wait_done("rd0", 1, 4);

      // Write timeout: second word's bytes are drained
      resp_never = 1'b1;
      last_run = 0;
      exp_tx.push_back(8'hFE);
      pkt = '{8'h81, 8'h00, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04,
              8'h05, 8'h06, 8'h07, 8'h08};
      send_pkt();
      wait_done("tmo", 0, 1);
      check("tmo_avalid_cycles", last_run, 16);
      resp_never = 1'b0;

      // Address wrap with tx backpressure mid-response
      rd_q.push_back(32'h01020304);
      rd_q.push_back(32'h05060708);
      exp_req.push_back('{1'b0, 14'h3FFF, 32'h0});
      exp_req.push_back('{1'b0, 14'h0000, 32'h0});
      exp_tx = '{8'h04, 8'h03, 8'h02, 8'h01, 8'h08, 8'h07, 8'h06, 8'h05};
      stall_after = 2;
      pkt = '{8'h01, 8'hFC, 8'hFF};
      send_pkt();
      wait_done("wrap", 2, 8);

      // Async reset while a request is outstanding
      resp_never = 1'b1;
      pkt = '{8'h80, 8'h10, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
      send_pkt();
      for (int i = 0; i < 50; i++) begin
         @(negedge clk_48);
         if (avalid) break;
      end
      check("rstmid_pre_avalid", avalid, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("rstmid_avalid", avalid, 1'b0);
      check("rstmid_tx_valid", tx_valid, 1'b0);
      check("rstmid_busy", busy, 1'b0);
      repeat (2) @(posedge clk_48);
      #1 rst_n = 1'b1;
      resp_never = 1'b0;
      req_seen = 0;
      tx_seen  = 0;
      exp_req.push_back('{1'b1, 14'h002A, 32'hDEADBEEF});
      exp_tx.push_back(8'h00);
      pkt = '{8'h80, 8'hA8, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
      send_pkt();
      wait_done("after_rst", 1, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
